// File: rtl/alu_pkg.sv
// Shared constants and types for the pipelined 8-bit carry-lookahead adder.
//
// Contents:
//   WIDTH_ALU  - datapath width (8; two 4-bit lookahead groups)
//   GROUP_W    - width of one carry-lookahead group
//   FLAG_*     - bit positions of the status flag vector {neg, zero, ovf, cout}
//   s1_t       - contents of the first pipeline register
package alu_pkg;

    localparam int WIDTH_ALU = 8;
    localparam int GROUP_W   = 4;

    // Flag vector bit order, MSB to LSB: {neg, zero, ovf, cout}
    localparam int FLAG_W    = 4;
    localparam int FLAG_COUT = 0;
    localparam int FLAG_OVF  = 1;
    localparam int FLAG_ZERO = 2;
    localparam int FLAG_NEG  = 3;

    // Everything the upper nibble still needs once the lower nibble is resolved
    typedef struct packed {
        logic [GROUP_W-1:0] sum_lo;
        logic               c4;
        logic [GROUP_W-1:0] p_hi;
        logic [GROUP_W-1:0] g_hi;
    } s1_t;

endpackage

// File: rtl/pipelined_cla_adder8_if.sv
// Operand/result handshake bundle for pipelined_cla_adder8.
//
// Signals:
//   in_valid/in_ready   - operand beat handshake (a, b, cin, sub)
//   out_valid/out_ready - result handshake (sum, cout, ovf, zero, neg)
// Modports:
//   master - producer of operands / consumer of results
//   slave  - the adder itself
interface pipelined_cla_adder8_if
    import alu_pkg::*;
    ();

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH_ALU-1:0] a;
    logic [WIDTH_ALU-1:0] b;
    logic                 cin;
    logic                 sub;

    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH_ALU-1:0] sum;
    logic                 cout;
    logic                 ovf;
    logic                 zero;
    logic                 neg;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero, neg
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero, neg
    );

endinterface

// File: rtl/carry_lookahead_unit.sv
// One 4-bit carry-lookahead group.
//
// Every carry is a flat sum of products of g/p and the group carry-in, so no
// carry waits on the one below it.
//
// Ports:
//   p, g  - group propagate / generate bits
//   c_in  - carry into the group
//   c     - carry into each bit of the group (c[0] == c_in)
//   c_out - carry out of the group
module carry_lookahead_unit
    import alu_pkg::*;
    (
    input  logic [GROUP_W-1:0] p,
    input  logic [GROUP_W-1:0] g,
    input  logic               c_in,
    output logic [GROUP_W-1:0] c,
    output logic               c_out
);

    assign c[0]  = c_in;
    assign c[1]  = g[0] | (p[0] & c_in);
    assign c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    assign c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                 | (p[2] & p[1] & p[0] & c_in);
    assign c_out = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0])
                 | (p[3] & p[2] & p[1] & p[0] & c_in);

endmodule

// File: rtl/pg_gen.sv
// Operand conditioning and per-bit generate/propagate terms.
//
// Subtraction is done as A + ~B + 1, so B is inverted and the carry-in is
// flipped: a borrow-in of 1 then becomes a carry-in of 0.
//
// Ports:
//   a, b  - operands
//   sub   - 1 selects subtraction
//   cin   - carry-in (add) / borrow-in (sub)
//   p, g  - per-bit propagate / generate
//   c0    - carry into bit 0
module pg_gen
    import alu_pkg::*;
    (
    input  logic [WIDTH_ALU-1:0] a,
    input  logic [WIDTH_ALU-1:0] b,
    input  logic                 sub,
    input  logic                 cin,
    output logic [WIDTH_ALU-1:0] p,
    output logic [WIDTH_ALU-1:0] g,
    output logic                 c0
);

    logic [WIDTH_ALU-1:0] b_cond;

    assign b_cond = sub ? ~b : b;
    assign p      = a ^ b_cond;
    assign g      = a & b_cond;
    assign c0     = cin ^ sub;

endmodule

// File: rtl/pipelined_cla_adder8.sv
// Two-stage pipelined 8-bit add/subtract with status flags.
//
// Stage 1 resolves the low nibble with its lookahead group and keeps the
// high nibble's p/g plus the nibble carry. Stage 2 resolves the high nibble
// and registers the result and flags. Both stages use valid/ready flow control
// and hold up to two beats.
//
// Ports:
//   clk, rst - rising-edge clock, asynchronous active-high reset
//   bus      - slave side of pipelined_cla_adder8_if
//              (operands a/b/cin/sub in, sum/cout/ovf/zero/neg out)
// Only WIDTH = 8 is meaningful.
module pipelined_cla_adder8
    import alu_pkg::*;
    #(
    parameter int WIDTH = WIDTH_ALU
    ) (
    input  logic                    clk,
    input  logic                    rst,
    pipelined_cla_adder8_if.slave   bus
);

    logic [WIDTH-1:0]   p;
    logic [WIDTH-1:0]   g;
    logic               c0;
    logic [GROUP_W-1:0] c_lo;
    logic               c4;
    logic [GROUP_W-1:0] c_hi;
    logic               c8;

    s1_t                s1_q;
    logic               s1_valid;
    s1_t                s1_next;

    logic               out_valid_q;
    logic [WIDTH-1:0]   sum_q;
    logic [FLAG_W-1:0]  flags_q;
    logic [WIDTH-1:0]   sum_next;
    logic [FLAG_W-1:0]  flags_next;

    logic               accept;
    logic               advance;

    pg_gen u_pg (
        .a   (bus.a),
        .b   (bus.b),
        .sub (bus.sub),
        .cin (bus.cin),
        .p   (p),
        .g   (g),
        .c0  (c0)
    );

    carry_lookahead_unit u_cla_lo (
        .p     (p[GROUP_W-1:0]),
        .g     (g[GROUP_W-1:0]),
        .c_in  (c0),
        .c     (c_lo),
        .c_out (c4)
    );

    carry_lookahead_unit u_cla_hi (
        .p     (s1_q.p_hi),
        .g     (s1_q.g_hi),
        .c_in  (s1_q.c4),
        .c     (c_hi),
        .c_out (c8)
    );

    // Stage 1 may refill in the same cycle it empties into stage 2, which is
    // what keeps the pipe at one beat per cycle. in_ready looks only at
    // out_ready and the stage valids, never at in_valid.
    assign bus.in_ready = !s1_valid || !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign advance      = s1_valid && (!out_valid_q || bus.out_ready);

    assign s1_next.sum_lo = p[GROUP_W-1:0] ^ c_lo;
    assign s1_next.c4     = c4;
    assign s1_next.p_hi   = p[WIDTH-1:GROUP_W];
    assign s1_next.g_hi   = g[WIDTH-1:GROUP_W];

    // Upper nibble sum and flags. The carry into bit 7 is c_hi[3], so signed
    // overflow is the disagreement between the carries into and out of bit 7.
    always_comb begin
        sum_next              = '0;
        flags_next            = '0;
        sum_next              = {s1_q.p_hi ^ c_hi, s1_q.sum_lo};
        flags_next[FLAG_COUT] = c8;
        flags_next[FLAG_OVF]  = c8 ^ c_hi[GROUP_W-1];
        flags_next[FLAG_ZERO] = (sum_next == '0);
        flags_next[FLAG_NEG]  = sum_next[WIDTH-1];
    end

    // Stage 1 register: loads on accept, otherwise empties when its beat
    // moves on to stage 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_q     <= s1_next;
        end else if (advance) begin
            s1_valid <= 1'b0;
        end
    end

    // Output register: loads when stage 1 advances, drops valid once the
    // consumer takes a result with nothing behind it, and otherwise holds
    // still under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            flags_q     <= '0;
        end else if (advance) begin
            out_valid_q <= 1'b1;
            sum_q       <= sum_next;
            flags_q     <= flags_next;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = flags_q[FLAG_COUT];
    assign bus.ovf       = flags_q[FLAG_OVF];
    assign bus.zero      = flags_q[FLAG_ZERO];
    assign bus.neg       = flags_q[FLAG_NEG];

endmodule

// File: tb/tb_pipelined_cla_adder8.sv
// Testbench for pipelined_cla_adder8: directed arithmetic cases,
// backpressure, back-to-back streaming, random stalls and reset mid-flight.
module tb_pipelined_cla_adder8;

    typedef struct packed {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
        logic       zero;
        logic       neg;
    } result_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    result_t exp_q[$];

    pipelined_cla_adder8_if bus ();

    pipelined_cla_adder8 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Arithmetic reference: plain integer add/subtract, unsigned for
    // sum/cout, signed range check for ovf.
    function automatic result_t model(input logic [7:0] a, input logic [7:0] b,
                                      input logic cin, input logic sub);
        int ua, ub, sa, sb, ci, r, sr;
        result_t res;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        ci = cin ? 1 : 0;
        if (!sub) begin
            r  = ua + ub + ci;
            sr = sa + sb + ci;
            res.cout = (r > 255);
        end else begin
            r  = ua - ub - ci;
            sr = sa - sb - ci;
            res.cout = (r >= 0);
        end
        res.sum  = r[7:0];
        res.ovf  = (sr > 127) || (sr < -128);
        res.zero = (res.sum == 8'h00);
        res.neg  = res.sum[7];
        return res;
    endfunction

    function automatic result_t observed();
        return {bus.sum, bus.cout, bus.ovf, bus.zero, bus.neg};
    endfunction

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                                 input logic cin, input logic sub);
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.sub      = sub;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid);
        end
        checks++;
        if (observed() !== result_t'(0)) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %03h expected 000", observed());
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready);
        end
    endtask

    task automatic test_directed();
        logic [7:0] va[5]  = '{8'h0F, 8'h7F, 8'hFF, 8'h05, 8'h80};
        logic [7:0] vb[5]  = '{8'h01, 8'h01, 8'h01, 8'h07, 8'h01};
        logic       vs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        result_t    ve[5]  = '{{8'h10, 1'b0, 1'b0, 1'b0, 1'b0},
                               {8'h80, 1'b0, 1'b1, 1'b0, 1'b1},
                               {8'h00, 1'b1, 1'b0, 1'b1, 1'b0},
                               {8'hFE, 1'b0, 1'b0, 1'b0, 1'b1},
                               {8'h7F, 1'b1, 1'b1, 1'b0, 1'b0}};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            applyStimulus(va[i], vb[i], 1'b0, vs[i]);
            @(posedge clk);
            @(negedge clk);
            bus.in_valid = 1'b0;
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL directed%0d_early_valid: got %b expected 0", i, bus.out_valid);
            end
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL directed%0d_valid: got %b expected 1", i, bus.out_valid);
            end
            checks++;
            if (observed() !== ve[i]) begin
                errors++;
                $display("[TB] FAIL directed%0d_result: got %03h expected %03h", i, observed(), ve[i]);
            end
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL directed%0d_drain: got %b expected 0", i, bus.out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        bus.out_ready = 1'b0;
        applyStimulus(8'd1, 8'd1, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        applyStimulus(8'd2, 8'd2, 1'b0, 1'b0);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_second_ready: got %b expected 1", bus.in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        applyStimulus(8'd3, 8'd3, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.sum !== 8'h02) begin
                errors++;
                $display("[TB] FAIL bp_hold%0d: got valid=%b sum=%02h expected valid=1 sum=02", i, bus.out_valid, bus.sum);
            end
            checks++;
            if (bus.in_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL bp_full%0d: got in_ready=%b expected 0", i, bus.in_ready);
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_release_ready: got %b expected 1", bus.in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.sum !== 8'h04) begin
            errors++;
            $display("[TB] FAIL bp_drain2: got valid=%b sum=%02h expected valid=1 sum=04", bus.out_valid, bus.sum);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.sum !== 8'h06) begin
            errors++;
            $display("[TB] FAIL bp_drain3: got valid=%b sum=%02h expected valid=1 sum=06", bus.out_valid, bus.sum);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_empty: got %b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int sent = 0, got = 0, first = -1, last = -1;
        result_t exp;
        logic [7:0] ra, rb;
        logic rc, rs;
        exp_q.delete();
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && got < 16; cyc++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                if (first < 0) first = cyc;
                last = cyc;
                got++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL b2b_extra: got %03h expected no result", observed());
                end else begin
                    exp = exp_q.pop_front();
                    if (observed() !== exp) begin
                        errors++;
                        $display("[TB] FAIL b2b_result%0d: got %03h expected %03h", got, observed(), exp);
                    end
                end
            end
            if (sent < 16) begin
                ra = 8'($urandom); rb = 8'($urandom);
                rc = 1'($urandom); rs = 1'($urandom);
                applyStimulus(ra, rb, rc, rs);
                exp_q.push_back(model(ra, rb, rc, rs));
                sent++;
                #1;
                checks++;
                if (bus.in_ready !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL b2b_ready%0d: got %b expected 1", sent, bus.in_ready);
                end
            end else begin
                bus.in_valid = 1'b0;
            end
        end
        bus.in_valid = 1'b0;
        checks++;
        if (got != 16 || (last - first + 1) != 16) begin
            errors++;
            $display("[TB] FAIL b2b_stream: got %0d results over %0d cycles expected 16 over 16", got, last - first + 1);
        end
    endtask

    task automatic test_random_stall();
        int sent = 0, got = 0;
        logic held = 1'b0;
        result_t held_val, exp;
        logic [7:0] ra, rb;
        logic rc, rs, in_fire, out_fire;
        exp_q.delete();
        @(negedge clk);
        for (int cyc = 0; cyc < 600 && got < 40; cyc++) begin
            if (held) begin
                checks++;
                if (bus.out_valid !== 1'b1 || observed() !== held_val) begin
                    errors++;
                    $display("[TB] FAIL stall_hold: got valid=%b %03h expected valid=1 %03h", bus.out_valid, observed(), held_val);
                end
            end
            bus.out_ready = 1'($urandom_range(0, 2) != 0);
            if (sent < 40 && $urandom_range(0, 3) != 0) begin
                ra = 8'($urandom); rb = 8'($urandom);
                rc = 1'($urandom); rs = 1'($urandom);
                applyStimulus(ra, rb, rc, rs);
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            in_fire  = bus.in_valid && bus.in_ready;
            out_fire = bus.out_valid && bus.out_ready;
            if (in_fire) begin
                exp_q.push_back(model(ra, rb, rc, rs));
                sent++;
            end
            if (out_fire) begin
                got++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL stall_extra: got %03h expected no result", observed());
                end else begin
                    exp = exp_q.pop_front();
                    if (observed() !== exp) begin
                        errors++;
                        $display("[TB] FAIL stall_result%0d: got %03h expected %03h", got, observed(), exp);
                    end
                end
            end
            held     = bus.out_valid && !bus.out_ready;
            held_val = observed();
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        checks++;
        if (got != 40) begin
            errors++;
            $display("[TB] FAIL stall_count: got %0d results expected 40", got);
        end
    endtask

    task automatic test_reset_mid_flight();
        int stale = 0;
        result_t exp;
        @(negedge clk);
        bus.out_ready = 1'b0;
        applyStimulus(8'h11, 8'h22, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        applyStimulus(8'h33, 8'h44, 1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.sum !== 8'h33) begin
            errors++;
            $display("[TB] FAIL rst_pre: got valid=%b sum=%02h expected valid=1 sum=33", bus.out_valid, bus.sum);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || observed() !== result_t'(0)) begin
            errors++;
            $display("[TB] FAIL rst_async: got valid=%b %03h expected valid=0 000", bus.out_valid, observed());
        end
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) stale++;
        end
        checks++;
        if (stale != 0) begin
            errors++;
            $display("[TB] FAIL rst_stale: got %0d valid cycles expected 0", stale);
        end
        applyStimulus(8'hA5, 8'h5A, 1'b1, 1'b1);
        exp = model(8'hA5, 8'h5A, 1'b1, 1'b1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || observed() !== exp) begin
            errors++;
            $display("[TB] FAIL rst_after: got valid=%b %03h expected valid=1 %03h", bus.out_valid, observed(), exp);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        $display("[TB] starting pipelined_cla_adder8 bench");
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_random_stall();
        test_reset_mid_flight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
